// File: rtl/vend_pkg.sv
// vend_pkg: shared types and helpers for the vending-machine controller.
//   state_e      - controller FSM states
//   COIN_*       - coin acceptor codes
//   coin_value() - coin code to credit units
package vend_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VEND    = 2'd2,
        S_CHANGE  = 2'd3
    } state_e;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_1    = 2'b01;
    localparam logic [1:0] COIN_2    = 2'b10;
    localparam logic [1:0] COIN_5    = 2'b11;

    function automatic logic [2:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_1:  return 3'd1;
            COIN_2:  return 3'd2;
            COIN_5:  return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_stock.sv
// vend_stock: per-slot stock counters.
//   CLK, RST_N   - clock, asynchronous active-low reset (all slots full)
//   refill_i     - set every counter to STOCK_MAX
//   dec_i        - decrement the counter selected by dec_slot_i
//   dec_slot_i   - slot index for decrement
//   empty_o      - registered per-slot "stock is zero" flags
module vend_stock
    import vend_pkg::*;
#(
    parameter int N_SLOT    = 4,
    parameter int STOCK_MAX = 8
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      refill_i,
    input  logic                      dec_i,
    input  logic [$clog2(N_SLOT)-1:0] dec_slot_i,
    output logic [N_SLOT-1:0]         empty_o
);

    localparam int SEL_W = $clog2(N_SLOT);
    localparam int CNT_W = $clog2(STOCK_MAX + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(STOCK_MAX);

    logic [CNT_W-1:0]  stock_q [N_SLOT];
    logic [CNT_W-1:0]  stock_d [N_SLOT];
    logic [N_SLOT-1:0] empty_q;
    logic [N_SLOT-1:0] empty_d;

    // EMPTY is computed from the next counter value so it stays a plain register.
    always_comb begin
        empty_d = '0;
        for (int unsigned i = 0; i < N_SLOT; i++) begin
            stock_d[i] = stock_q[i];
            if (refill_i) begin
                stock_d[i] = FULL;
            end else if (dec_i && (dec_slot_i == SEL_W'(i)) && (stock_q[i] != '0)) begin
                stock_d[i] = stock_q[i] - CNT_W'(1);
            end
            empty_d[i] = (stock_d[i] == '0);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < N_SLOT; i++) begin
                stock_q[i] <= FULL;
            end
            empty_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_SLOT; i++) begin
                stock_q[i] <= stock_d[i];
            end
            empty_q <= empty_d;
        end
    end

    assign empty_o = empty_q;

endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: vending-machine controller (FSM, credit, timeout, pulse outputs).
//   CLK, RST_N  - clock, asynchronous active-low reset
//   ST          - machine enable
//   CN          - coin code pulse (00 none, 01=1, 10=2, 11=5 units)
//   SEL, SEL_V  - slot index and selection strobe
//   CANCEL      - refund request
//   REFILL      - restock all slots (IDLE only)
//   CREDIT      - current credit
//   VEND_V      - dispense pulse, VEND_SLOT - slot being dispensed
//   CHG_P       - one change unit per asserted cycle
//   COIN_REJ    - coin returned pulse, SEL_ERR - selection refused pulse
//   EMPTY       - per-slot stock-zero flags
//   BUSY        - controller not in IDLE
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int N_SLOT      = 4,
    parameter int CREDIT_W    = 6,
    parameter int PRICE       = 7,
    parameter int MAX_CREDIT  = 40,
    parameter int STOCK_MAX   = 8,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      ST,
    input  logic [1:0]                CN,
    input  logic [$clog2(N_SLOT)-1:0] SEL,
    input  logic                      SEL_V,
    input  logic                      CANCEL,
    input  logic                      REFILL,
    output logic [CREDIT_W-1:0]       CREDIT,
    output logic                      VEND_V,
    output logic [$clog2(N_SLOT)-1:0] VEND_SLOT,
    output logic                      CHG_P,
    output logic                      COIN_REJ,
    output logic                      SEL_ERR,
    output logic [N_SLOT-1:0]         EMPTY,
    output logic                      BUSY
);

    localparam int SEL_W = $clog2(N_SLOT);
    localparam int SUM_W = CREDIT_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
    localparam logic [SUM_W-1:0]    MAX_C    = SUM_W'(MAX_CREDIT);
    localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                vend_v_q, vend_v_d;
    logic [SEL_W-1:0]    vend_slot_q, vend_slot_d;
    logic                chg_p_q, chg_p_d;
    logic                coin_rej_q, coin_rej_d;
    logic                sel_err_q, sel_err_d;
    logic                busy_q;

    logic                coin;
    logic [SUM_W-1:0]    sum;
    logic                coin_ok;
    logic                refill;
    logic                dec;
    logic [N_SLOT-1:0]   empty;

    vend_stock #(
        .N_SLOT    (N_SLOT),
        .STOCK_MAX (STOCK_MAX)
    ) u_stock (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .refill_i   (refill),
        .dec_i      (dec),
        .dec_slot_i (vend_slot_q),
        .empty_o    (empty)
    );

    assign coin    = (CN != COIN_NONE);
    assign sum     = {1'b0, credit_q} + SUM_W'(coin_value(CN));
    assign coin_ok = (sum <= MAX_C);

    always_comb begin
        state_d     = state_q;
        credit_d    = credit_q;
        tmo_d       = '0;
        vend_v_d    = 1'b0;
        vend_slot_d = vend_slot_q;
        chg_p_d     = 1'b0;
        coin_rej_d  = 1'b0;
        sel_err_d   = 1'b0;
        refill      = 1'b0;
        dec         = 1'b0;

        case (state_q)
            S_IDLE: begin
                refill    = REFILL;
                sel_err_d = SEL_V;
                if (coin) begin
                    if (ST && coin_ok) begin
                        credit_d = sum[CREDIT_W-1:0];
                        state_d  = S_COLLECT;
                    end else begin
                        coin_rej_d = 1'b1;
                    end
                end
            end

            S_COLLECT: begin
                if (CANCEL || !ST) begin
                    coin_rej_d = coin;
                    state_d    = S_CHANGE;
                end else if (coin) begin
                    // Any coin, accepted or not, counts as activity.
                    if (coin_ok) begin
                        credit_d = sum[CREDIT_W-1:0];
                    end else begin
                        coin_rej_d = 1'b1;
                    end
                end else if (SEL_V && !empty[SEL] && (credit_q >= PRICE_C)) begin
                    vend_v_d    = 1'b1;
                    vend_slot_d = SEL;
                    state_d     = S_VEND;
                end else begin
                    sel_err_d = SEL_V;
                    // The counter reaches TIMEOUT_CYC on the edge that leaves for CHANGE.
                    if (tmo_q >= TMO_LAST) begin
                        state_d = S_CHANGE;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
            end

            S_VEND: begin
                coin_rej_d = coin;
                dec        = 1'b1;
                credit_d   = credit_q - PRICE_C;
                state_d    = (credit_q > PRICE_C) ? S_CHANGE : S_IDLE;
            end

            S_CHANGE: begin
                coin_rej_d = coin;
                if (credit_q != '0) begin
                    chg_p_d  = 1'b1;
                    credit_d = credit_q - CREDIT_W'(1);
                    if (credit_q == CREDIT_W'(1)) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            credit_q    <= '0;
            tmo_q       <= '0;
            vend_v_q    <= 1'b0;
            vend_slot_q <= '0;
            chg_p_q     <= 1'b0;
            coin_rej_q  <= 1'b0;
            sel_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            tmo_q       <= tmo_d;
            vend_v_q    <= vend_v_d;
            vend_slot_q <= vend_slot_d;
            chg_p_q     <= chg_p_d;
            coin_rej_q  <= coin_rej_d;
            sel_err_q   <= sel_err_d;
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign CREDIT    = credit_q;
    assign VEND_V    = vend_v_q;
    assign VEND_SLOT = vend_slot_q;
    assign CHG_P     = chg_p_q;
    assign COIN_REJ  = coin_rej_q;
    assign SEL_ERR   = sel_err_q;
    assign EMPTY     = empty;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: scoreboard bench for vend_ctrl with a transaction-level model.
module tb_vend_ctrl;

    localparam int N_SLOT      = 4;
    localparam int CREDIT_W    = 6;
    localparam int PRICE       = 7;
    localparam int MAX_CREDIT  = 40;
    localparam int STOCK_MAX   = 8;
    localparam int TIMEOUT_CYC = 1000;
    localparam int SEL_W       = $clog2(N_SLOT);

    logic                CLK = 1'b0;
    logic                RST_N;
    logic                ST;
    logic [1:0]          CN;
    logic [SEL_W-1:0]    SEL;
    logic                SEL_V;
    logic                CANCEL;
    logic                REFILL;
    logic [CREDIT_W-1:0] CREDIT;
    logic                VEND_V;
    logic [SEL_W-1:0]    VEND_SLOT;
    logic                CHG_P;
    logic                COIN_REJ;
    logic                SEL_ERR;
    logic [N_SLOT-1:0]   EMPTY;
    logic                BUSY;

    always #5 CLK = ~CLK;

    vend_ctrl #(
        .N_SLOT      (N_SLOT),
        .CREDIT_W    (CREDIT_W),
        .PRICE       (PRICE),
        .MAX_CREDIT  (MAX_CREDIT),
        .STOCK_MAX   (STOCK_MAX),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .ST        (ST),
        .CN        (CN),
        .SEL       (SEL),
        .SEL_V     (SEL_V),
        .CANCEL    (CANCEL),
        .REFILL    (REFILL),
        .CREDIT    (CREDIT),
        .VEND_V    (VEND_V),
        .VEND_SLOT (VEND_SLOT),
        .CHG_P     (CHG_P),
        .COIN_REJ  (COIN_REJ),
        .SEL_ERR   (SEL_ERR),
        .EMPTY     (EMPTY),
        .BUSY      (BUSY)
    );

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Expected events: cycle in which the pulse is seen (-1 = any) and a value.
    typedef struct { int cyc; int val; } ev_t;
    ev_t rej_q[$];
    ev_t selerr_q[$];
    ev_t vend_q[$];
    ev_t chg_q[$];

    // Reference model state.
    int m_credit;
    bit m_collect;
    int m_idle;
    int m_stock[N_SLOT];

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int coin_units(input bit [1:0] c);
        case (c)
            2'b01:   return 1;
            2'b10:   return 2;
            2'b11:   return 5;
            default: return 0;
        endcase
    endfunction

    function automatic logic [N_SLOT-1:0] m_empty();
        logic [N_SLOT-1:0] e;
        e = '0;
        for (int i = 0; i < N_SLOT; i++) e[i] = (m_stock[i] == 0);
        return e;
    endfunction

    task automatic model_reset();
        m_credit  = 0;
        m_collect = 0;
        m_idle    = 0;
        for (int i = 0; i < N_SLOT; i++) m_stock[i] = STOCK_MAX;
        rej_q.delete();
        selerr_q.delete();
        vend_q.delete();
        chg_q.delete();
    endtask

    task automatic set_idle_inputs();
        ST = 1'b1; CN = 2'b00; SEL = '0; SEL_V = 1'b0; CANCEL = 1'b0; REFILL = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a pulse.
    int run_len   = 0;
    int run_start = 0;
    initial begin
        ev_t e;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                run_len = 0;
            end else begin
                if (COIN_REJ) begin
                    if (rej_q.size() == 0) chk("unexpected_coin_rej", 1, 0);
                    else begin e = rej_q.pop_front(); chk("coin_rej_cycle", cyc, e.cyc); end
                end
                if (SEL_ERR) begin
                    if (selerr_q.size() == 0) chk("unexpected_sel_err", 1, 0);
                    else begin e = selerr_q.pop_front(); chk("sel_err_cycle", cyc, e.cyc); end
                end
                if (VEND_V) begin
                    if (vend_q.size() == 0) chk("unexpected_vend", 1, 0);
                    else begin
                        e = vend_q.pop_front();
                        chk("vend_cycle", cyc, e.cyc);
                        chk("vend_slot", VEND_SLOT, e.val);
                    end
                end
                if (CHG_P) begin
                    if (run_len == 0) run_start = cyc;
                    run_len++;
                end else if (run_len > 0) begin
                    if (chg_q.size() == 0) chk("unexpected_change_run", run_len, 0);
                    else begin
                        e = chg_q.pop_front();
                        if (e.cyc >= 0) chk("change_start", run_start, e.cyc);
                        chk("change_units", run_len, e.val);
                    end
                    run_len = 0;
                end
            end
        end
    end

    // Random inputs while the controller is vending or returning change:
    // every coin must come back, everything else is ignored.
    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            ST     = ($urandom_range(0, 3) != 0);
            CN     = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            SEL    = SEL_W'($urandom_range(0, N_SLOT - 1));
            SEL_V  = ($urandom_range(0, 3) == 0);
            CANCEL = ($urandom_range(0, 5) == 0);
            REFILL = ($urandom_range(0, 5) == 0);
            if (CN != 2'b00) rej_q.push_back('{cyc + 1, 0});
            @(posedge CLK);
            #1;
            set_idle_inputs();
        end
    endtask

    // One stimulus cycle while IDLE or collecting, then any vend/change that follows.
    task automatic txn(input bit st, input bit [1:0] cn, input int sel,
                       input bit selv, input bit cancel, input bit refill);
        int e;
        int val;
        int busy;
        int k;
        busy = 0;
        @(negedge CLK);
        ST = st; CN = cn; SEL = SEL_W'(sel); SEL_V = selv; CANCEL = cancel; REFILL = refill;
        e   = cyc + 1;
        val = coin_units(cn);
        if (!m_collect) begin
            if (refill) for (int i = 0; i < N_SLOT; i++) m_stock[i] = STOCK_MAX;
            if (selv) selerr_q.push_back('{e, 0});
            if (cn != 2'b00) begin
                if (st && val <= MAX_CREDIT) begin
                    m_credit  = val;
                    m_collect = 1;
                    m_idle    = 0;
                end else begin
                    rej_q.push_back('{e, 0});
                end
            end
        end else if (cancel || !st) begin
            if (cn != 2'b00) rej_q.push_back('{e, 0});
            chg_q.push_back('{e + 1, m_credit});
            busy = m_credit;
        end else if (cn != 2'b00) begin
            m_idle = 0;
            if (m_credit + val <= MAX_CREDIT) m_credit += val;
            else rej_q.push_back('{e, 0});
        end else if (selv && m_stock[sel] > 0 && m_credit >= PRICE) begin
            vend_q.push_back('{e, sel});
            m_stock[sel]--;
            k = m_credit - PRICE;
            if (k > 0) chg_q.push_back('{e + 2, k});
            busy = 1 + k;
        end else begin
            if (selv) selerr_q.push_back('{e, 0});
            m_idle++;
        end
        @(posedge CLK);
        #1;
        set_idle_inputs();
        chk("credit_after_edge", CREDIT, m_credit);
        if (busy > 0) begin
            chk("busy_while_serving", BUSY, 1);
            m_credit  = 0;
            m_collect = 0;
            drain(busy);
        end
        chk("credit", CREDIT, m_credit);
        chk("busy", BUSY, m_collect);
        chk("empty", EMPTY, m_empty());
    endtask

    task automatic idle_cycle();
        @(negedge CLK);
        set_idle_inputs();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        #1;
        model_reset();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        set_idle_inputs();
        RST_N = 1'b0;
        model_reset();
        #1;
        chk("reset_credit", CREDIT, 0);
        chk("reset_vend_v", VEND_V, 0);
        chk("reset_vend_slot", VEND_SLOT, 0);
        chk("reset_chg_p", CHG_P, 0);
        chk("reset_coin_rej", COIN_REJ, 0);
        chk("reset_sel_err", SEL_ERR, 0);
        chk("reset_empty", EMPTY, 0);
        chk("reset_busy", BUSY, 0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        idle_cycle();
        chk("idle_after_reset", BUSY, 0);

        // Exact price, slot 2, no change.
        txn(1, 2'b11, 0, 0, 0, 0);
        txn(1, 2'b10, 0, 0, 0, 0);
        txn(1, 2'b00, 2, 1, 0, 0);

        // Ten units, slot 1, three units of change.
        txn(1, 2'b11, 0, 0, 0, 0);
        txn(1, 2'b11, 0, 0, 0, 0);
        txn(1, 2'b00, 1, 1, 0, 0);

        // Fill to the ceiling, one more coin is refused, cancel refunds 40.
        for (int i = 0; i < 8; i++) txn(1, 2'b11, 0, 0, 0, 0);
        txn(1, 2'b01, 0, 0, 0, 0);
        txn(1, 2'b00, 0, 0, 1, 0);

        // Empty slot 0, refused selection keeps credit, refill clears EMPTY.
        txn(1, 2'b00, 0, 0, 0, 1);
        for (int i = 0; i < STOCK_MAX; i++) begin
            txn(1, 2'b11, 0, 0, 0, 0);
            txn(1, 2'b10, 0, 0, 0, 0);
            txn(1, 2'b00, 0, 1, 0, 0);
        end
        txn(1, 2'b11, 0, 0, 0, 0);
        txn(1, 2'b10, 0, 0, 0, 0);
        txn(1, 2'b00, 0, 1, 0, 0);
        txn(1, 2'b00, 0, 0, 1, 0);
        txn(1, 2'b00, 0, 0, 0, 1);

        // Coin beats selection in the same cycle, then inactivity refund.
        txn(1, 2'b11, 0, 0, 0, 0);
        txn(1, 2'b01, 0, 0, 0, 0);
        txn(1, 2'b01, 3, 1, 0, 0);
        chg_q.push_back('{-1, m_credit});
        repeat (TIMEOUT_CYC - 10) idle_cycle();
        chk("timeout_not_early_busy", BUSY, 1);
        chk("timeout_not_early_credit", CREDIT, 7);
        for (int i = 0; i < 100; i++) begin
            if (!BUSY) break;
            idle_cycle();
        end
        chk("timeout_refund_done", BUSY, 0);
        chk("timeout_credit", CREDIT, 0);
        m_credit  = 0;
        m_collect = 0;

        // Reset during change: refund is abandoned immediately.
        txn(1, 2'b11, 0, 0, 0, 0);
        txn(1, 2'b11, 0, 0, 0, 0);
        txn(1, 2'b11, 0, 0, 0, 0);
        @(negedge CLK);
        CANCEL = 1'b1;
        @(posedge CLK);
        #1;
        set_idle_inputs();
        repeat (3) idle_cycle();
        chk("chg_p_before_reset", CHG_P, 1);
        do_reset();
        chk("chg_p_in_reset", CHG_P, 0);
        chk("credit_in_reset", CREDIT, 0);
        chk("busy_in_reset", BUSY, 0);
        idle_cycle();
        chk("credit_after_reset", CREDIT, 0);

        // Randomised traffic.
        for (int n = 0; n < 300; n++) begin
            if (m_collect && m_idle > 300) begin
                txn(1, 2'b00, 0, 0, 1, 0);
            end else begin
                txn(($urandom_range(0, 15) != 0),
                    ($urandom_range(0, 9) < 6) ? 2'($urandom_range(1, 3)) : 2'b00,
                    $urandom_range(0, N_SLOT - 1),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 24) == 0),
                    ($urandom_range(0, 29) == 0));
            end
        end
        if (m_collect) txn(1, 2'b00, 0, 0, 1, 0);

        repeat (5) idle_cycle();
        chk("pending_coin_rej", rej_q.size(), 0);
        chk("pending_sel_err", selerr_q.size(), 0);
        chk("pending_vend", vend_q.size(), 0);
        chk("pending_change", chg_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
